// File: rtl/condicionador_botoes.sv
// Synchronizes, debounces and one-hot filters seven push buttons into a note vector.
// Optional accepted-press counter on contagem, enabled by defining CONDICIONADOR_CONTAGEM_EN.
module condicionador_botoes #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] botoes_raw,
  output logic [6:0] botoes,
  output logic       pulso_jogada,
  output logic       multiplo,
  output logic [7:0] contagem,
  output logic [1:0] db_estado
);

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] SOLTO        = 2'd0;
  localparam logic [1:0] FILTRA_PRESS = 2'd1;
  localparam logic [1:0] PRESSIONADO  = 2'd2;
  localparam logic [1:0] FILTRA_SOLTA = 2'd3;

  logic [6:0]       sync1_q, sync1_d;
  logic [6:0]       sinc_q, sinc_d;
  logic [1:0]       estado_q, estado_d;
  logic [6:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       botoes_q, botoes_d;
  logic             pulso_q, pulso_d;
  logic             multiplo_q, multiplo_d;

  function automatic logic um_bit(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

  // Next-state logic: a candidate must stay identical for DEBOUNCE_CYCLES samples
  always_comb begin
    sync1_d    = botoes_raw;
    sinc_d     = sync1_q;
    estado_d   = estado_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    botoes_d   = botoes_q;
    pulso_d    = 1'b0;
    multiplo_d = multiplo_q;
    case (estado_q)
      SOLTO: begin
        if (sinc_q != 7'd0) begin
          cand_d   = sinc_q;
          cnt_d    = '0;
          estado_d = FILTRA_PRESS;
        end
      end
      FILTRA_PRESS: begin
        if (sinc_q == 7'd0) begin
          estado_d = SOLTO;
        end else if (sinc_q != cand_q) begin
          cand_d = sinc_q;
          cnt_d  = '0;
        end else if (cnt_q == LIMITE) begin
          estado_d = PRESSIONADO;
          // Chords are swallowed: flagged, never forwarded as a note
          if (um_bit(cand_q)) begin
            botoes_d = cand_q;
            pulso_d  = 1'b1;
          end else begin
            multiplo_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSIONADO: begin
        if (sinc_q == 7'd0) begin
          cnt_d    = '0;
          estado_d = FILTRA_SOLTA;
        end
      end
      FILTRA_SOLTA: begin
        if (sinc_q != 7'd0) begin
          estado_d = PRESSIONADO;
        end else if (cnt_q == LIMITE) begin
          botoes_d   = '0;
          multiplo_d = 1'b0;
          estado_d   = SOLTO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: estado_d = SOLTO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sinc_q     <= '0;
      estado_q   <= SOLTO;
      cand_q     <= '0;
      cnt_q      <= '0;
      botoes_q   <= '0;
      pulso_q    <= 1'b0;
      multiplo_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sinc_q     <= sinc_d;
      estado_q   <= estado_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      botoes_q   <= botoes_d;
      pulso_q    <= pulso_d;
      multiplo_q <= multiplo_d;
    end
  end

`ifdef CONDICIONADOR_CONTAGEM_EN
  logic [7:0] contagem_q, contagem_d;

  // Saturating count of accepted notes, stepping with the pulse it reports
  always_comb begin
    contagem_d = contagem_q;
    if (pulso_d && (contagem_q != 8'hFF)) contagem_d = contagem_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) contagem_q <= '0;
    else        contagem_q <= contagem_d;
  end

  assign contagem = contagem_q;
`else
  assign contagem = 8'd0;
`endif

  assign botoes       = botoes_q;
  assign pulso_jogada = pulso_q;
  assign multiplo     = multiplo_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Self-checking bench for condicionador_botoes: directed scenarios plus a
// random run against a run-length reference model of the debouncer.
module tb_condicionador_botoes;

  localparam int D   = 4;
  localparam int LAT = D + 3;
`ifdef CONDICIONADOR_CONTAGEM_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] botoes_raw;
  logic [6:0] botoes;
  logic       pulso_jogada;
  logic       multiplo;
  logic [7:0] contagem;
  logic [1:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  condicionador_botoes #(.DEBOUNCE_CYCLES(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes_raw   (botoes_raw),
    .botoes       (botoes),
    .pulso_jogada (pulso_jogada),
    .multiplo     (multiplo),
    .contagem     (contagem),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  // Reference: a value is accepted once the synchronized input has shown it
  // for D+1 consecutive samples; the mode flips between released and held.
  logic [6:0] h1, h2, s, run_val, m_botoes;
  logic       m_pulso, m_multi;
  logic [7:0] m_cont;
  int         run;
  bit         held;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      h1 = '0; h2 = '0; s = '0; run_val = '0; run = 0; held = 1'b0;
      m_botoes = '0; m_pulso = 1'b0; m_multi = 1'b0; m_cont = '0;
    end else begin
      s  = h2;
      h2 = h1;
      h1 = botoes_raw;
      if (s == run_val) run++;
      else begin
        run_val = s;
        run = 1;
      end
      m_pulso = 1'b0;
      if (!held && s != 7'd0 && run == D + 1) begin
        held = 1'b1;
        if ($countones(s) == 1) begin
          m_botoes = s;
          m_pulso  = 1'b1;
          if (CNT_EN && m_cont != 8'd255) m_cont = m_cont + 8'd1;
        end else begin
          m_multi = 1'b1;
        end
      end else if (held && s == 7'd0 && run == D + 1) begin
        held     = 1'b0;
        m_botoes = '0;
        m_multi  = 1'b0;
      end
    end
  end

  task automatic test_reset();
    botoes_raw = 7'b0000100;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (botoes !== 7'd0 || pulso_jogada !== 1'b0 || multiplo !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: botoes=%b pulso=%b multiplo=%b, required 0 0 0", botoes, pulso_jogada, multiplo);
    end
    n_cmp++;
    if (contagem !== 8'd0 || db_estado !== 2'd0) begin
      n_err++;
      $display("FAIL reset_async_cnt: contagem=%0d db_estado=%0d, required 0 0", contagem, db_estado);
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (botoes !== 7'd0 || pulso_jogada !== 1'b0 || db_estado !== 2'd0) begin
      n_err++;
      $display("FAIL reset_held: botoes=%b pulso=%b db_estado=%0d, required 0 0 0", botoes, pulso_jogada, db_estado);
    end
    botoes_raw = 7'd0;
    reset = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_single_press();
    logic [6:0] v = 7'b0000100;
    logic [6:0] exp_b;
    logic       exp_p;
    botoes_raw = v;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      exp_b = (i >= LAT) ? v : 7'd0;
      exp_p = (i == LAT);
      n_cmp++;
      if (botoes !== exp_b || pulso_jogada !== exp_p) begin
        n_err++;
        $display("FAIL press_lat i=%0d: botoes=%b pulso=%b, required %b %b", i, botoes, pulso_jogada, exp_b, exp_p);
      end
    end
    n_cmp++;
    if (db_estado !== 2'd2) begin
      n_err++;
      $display("FAIL press_state: db_estado=%0d, required 2", db_estado);
    end
    botoes_raw = 7'd0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      exp_b = (i >= LAT) ? 7'd0 : v;
      n_cmp++;
      if (botoes !== exp_b || pulso_jogada !== 1'b0) begin
        n_err++;
        $display("FAIL release_lat i=%0d: botoes=%b pulso=%b, required %b 0", i, botoes, pulso_jogada, exp_b);
      end
    end
    n_cmp++;
    if (db_estado !== 2'd0) begin
      n_err++;
      $display("FAIL release_state: db_estado=%0d, required 0", db_estado);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      botoes_raw = ((i / 2) % 2 == 0) ? 7'b0000001 : 7'd0;
      @(negedge clock);
      n_cmp++;
      if (botoes !== 7'd0 || pulso_jogada !== 1'b0) begin
        n_err++;
        $display("FAIL bounce i=%0d: botoes=%b pulso=%b, required 0 0", i, botoes, pulso_jogada);
      end
    end
    botoes_raw = 7'd0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_multi();
    botoes_raw = 7'b0010010;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      n_cmp++;
      if (botoes !== 7'd0 || pulso_jogada !== 1'b0 || multiplo !== (i >= LAT)) begin
        n_err++;
        $display("FAIL multi_press i=%0d: botoes=%b pulso=%b multiplo=%b, required 0 0 %b", i, botoes, pulso_jogada, multiplo, i >= LAT);
      end
    end
    botoes_raw = 7'd0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      n_cmp++;
      if (botoes !== 7'd0 || multiplo !== (i < LAT)) begin
        n_err++;
        $display("FAIL multi_release i=%0d: botoes=%b multiplo=%b, required 0 %b", i, botoes, multiplo, i < LAT);
      end
    end
  endtask

  task automatic test_add_bit();
    int pulses = 0;
    botoes_raw = 7'b0000001;
    repeat (10) begin
      @(negedge clock);
      if (pulso_jogada === 1'b1) pulses++;
    end
    botoes_raw = 7'b1000001;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (pulso_jogada === 1'b1) pulses++;
      n_cmp++;
      if (botoes !== 7'b0000001) begin
        n_err++;
        $display("FAIL add_bit i=%0d: botoes=%b, required 0000001", i, botoes);
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL add_bit_pulses: saw %0d pulses, required 1", pulses);
    end
    botoes_raw = 7'd0;
    repeat (10) @(negedge clock);
    n_cmp++;
    if (botoes !== 7'd0) begin
      n_err++;
      $display("FAIL add_bit_release: botoes=%b, required 0", botoes);
    end
  endtask

  task automatic test_reset_mid_press();
    logic [6:0] v = 7'b0000010;
    botoes_raw = v;
    repeat (10) @(negedge clock);
    n_cmp++;
    if (botoes !== v) begin
      n_err++;
      $display("FAIL midrst_pre: botoes=%b, required %b", botoes, v);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (botoes !== 7'd0 || pulso_jogada !== 1'b0 || multiplo !== 1'b0 || contagem !== 8'd0 || db_estado !== 2'd0) begin
      n_err++;
      $display("FAIL midrst_async: botoes=%b pulso=%b multiplo=%b contagem=%0d db=%0d, required all 0",
               botoes, pulso_jogada, multiplo, contagem, db_estado);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      n_cmp++;
      if (botoes !== ((i >= LAT) ? v : 7'd0) || pulso_jogada !== (i == LAT)) begin
        n_err++;
        $display("FAIL midrst_repress i=%0d: botoes=%b pulso=%b, required %b %b",
                 i, botoes, pulso_jogada, (i >= LAT) ? v : 7'd0, i == LAT);
      end
    end
    botoes_raw = 7'd0;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_random();
    logic [6:0] val;
    int         len;
    int         kind;
    for (int seg = 0; seg < 300; seg++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 0)      val = 7'd0;
      else if (kind == 1) val = 7'd1 << $urandom_range(0, 6);
      else if (kind == 2) val = 7'($urandom);
      else                val = (seg % 2 == 0) ? 7'd0 : (7'd1 << $urandom_range(0, 6));
      len = int'($urandom_range(1, 10));
      botoes_raw = val;
      repeat (len) begin
        @(negedge clock);
        n_cmp++;
        if (botoes !== m_botoes || pulso_jogada !== m_pulso || multiplo !== m_multi || contagem !== m_cont) begin
          n_err++;
          $display("FAIL random seg=%0d: botoes=%b pulso=%b multiplo=%b contagem=%0d, required %b %b %b %0d",
                   seg, botoes, pulso_jogada, multiplo, contagem, m_botoes, m_pulso, m_multi, m_cont);
        end
        n_cmp++;
        if ($countones(botoes) > 1) begin
          n_err++;
          $display("FAIL random_onehot seg=%0d: botoes=%b, required at most one bit", seg, botoes);
        end
      end
    end
    botoes_raw = 7'd0;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_count();
    int pulses = 0;
    int exp_c;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 260; k++) begin
      for (int c = 0; c < 16; c++) begin
        botoes_raw = (c < 8) ? (7'd1 << (k % 7)) : 7'd0;
        @(negedge clock);
        if (pulso_jogada === 1'b1) pulses++;
        exp_c = CNT_EN ? ((pulses > 255) ? 255 : pulses) : 0;
        n_cmp++;
        if (contagem !== 8'(exp_c)) begin
          n_err++;
          $display("FAIL count k=%0d: contagem=%0d, required %0d", k, contagem, exp_c);
        end
      end
    end
    n_cmp++;
    if (pulses != 260) begin
      n_err++;
      $display("FAIL count_pulses: saw %0d pulses, required 260", pulses);
    end
    n_cmp++;
    if (contagem !== (CNT_EN ? 8'd255 : 8'd0)) begin
      n_err++;
      $display("FAIL count_final: contagem=%0d, required %0d", contagem, CNT_EN ? 255 : 0);
    end
  endtask

  initial begin
    botoes_raw = 7'd0;
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_add_bit();
    test_reset_mid_press();
    test_random();
    test_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
